spc_nbit: RTL and testbench

SPC_NBIT -- requirements
Module: spc_nbit

---
 rtl/spc_nbit.sv | 137 +++++++++++++
 tb/tb_spc_nbit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spc_nbit.sv
// spc_nbit: serial-to-parallel converter with a selectable symbol width and an output FIFO.
//
// Bits arrive on din in cycles where en=1. They are gathered into symbols of 1, 2, 4 or 6 bits,
// chosen by mode. Each finished symbol goes into a DEPTH-entry FIFO. The FIFO head is offered
// on dout/dout_valid with a valid/ready handshake.
//
// Parameters
//   MAX_W  width of dout (6 or more); the symbol is right-aligned and the upper bits are 0
//   DEPTH  number of FIFO entries (a power of 2, 2 or more)
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   en          din is valid this cycle
//   din         serial data bit
//   mode        bits per symbol: 00=1, 01=2, 10=4, 11=6 (latched at the first bit of a symbol)
//   dout        FIFO head symbol (0 while dout_valid=0)
//   dout_valid  FIFO head holds a symbol
//   dout_ready  consumer accepts the head symbol when dout_valid=1
//   ovf         sticky: a completed symbol was dropped because the FIFO was full
//
// Build option
//   SPC_NBIT_LSB_FIRST_EN  when defined, the first bit of a symbol lands in bit 0 instead of
//                          bit N-1. Timing is the same in both builds.
module spc_nbit #(
  parameter int unsigned MAX_W = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic [1:0]       mode,
  output logic [MAX_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             ovf
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  function automatic logic [2:0] mode_width(input logic [1:0] m);
    logic [2:0] w;
    w = 3'd1;
    case (m)
      2'b00: w = 3'd1;
      2'b01: w = 3'd2;
      2'b10: w = 3'd4;
      2'b11: w = 3'd6;
    endcase
    return w;
  endfunction

  // Symbol assembly state
  logic [5:0] asm_q, asm_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] wid_q, wid_d;
  logic [2:0] wid_cur;
  logic [5:0] asm_base;
  logic       push;

  // FIFO state
  logic [5:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  logic          ovf_q;
  logic          full, pop, do_push;

  always_comb begin
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    wid_d    = wid_q;
    push     = 1'b0;
    // mode is only sampled at the first bit of a symbol
    wid_cur  = (cnt_q == 3'd0) ? mode_width(mode) : wid_q;
    asm_base = (cnt_q == 3'd0) ? 6'd0 : asm_q;
    if (en) begin
      wid_d = wid_cur;
`ifdef SPC_NBIT_LSB_FIRST_EN
      asm_d = asm_base | ({5'd0, din} << cnt_q);
`else
      asm_d = {asm_base[4:0], din};
`endif
      if (cnt_q + 3'd1 == wid_cur) begin
        push  = 1'b1;
        cnt_d = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  assign full       = (fcnt_q == CntW'(DEPTH));
  assign dout_valid = (fcnt_q != '0);
  assign pop        = dout_valid & dout_ready;
  // When the FIFO is full, a push still fits if a pop happens in the same cycle
  assign do_push    = push & (~full | pop);

  always_comb begin
    fcnt_d = fcnt_q;
    case ({do_push, pop})
      2'b10:   fcnt_d = fcnt_q + CntW'(1);
      2'b01:   fcnt_d = fcnt_q - CntW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      wid_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      cnt_q  <= cnt_d;
      wid_q  <= wid_d;
      fcnt_q <= fcnt_d;
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)     rptr_q <= rptr_q + PtrW'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= asm_d;
  end

  assign dout = dout_valid ? MAX_W'(mem_q[rptr_q]) : '0;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_spc_nbit.sv
module tb_spc_nbit;

  localparam int MaxW  = 6;
  localparam int Depth = 4;
`ifdef SPC_NBIT_LSB_FIRST_EN
  localparam bit Lsb = 1'b1;
`else
  localparam bit Lsb = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic            din = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic [MaxW-1:0] dout;
  logic            dout_valid;
  logic            dout_ready = 1'b0;
  logic            ovf;

  int n_checks = 0;
  int n_fail   = 0;

  spc_nbit #(.MAX_W(MaxW), .DEPTH(Depth)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .din        (din),
    .mode       (mode),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending bits and a queue of finished symbols
  bit m_on = 1'b0;
  bit bits[$];
  int fq[$];
  bit m_ovf;
  int m_w;
  int m_val;
  bit m_done, m_full, m_pop;

  function automatic int width_of(input logic [1:0] m);
    int w;
    if (m == 2'b00) w = 1;
    else if (m == 2'b01) w = 2;
    else if (m == 2'b10) w = 4;
    else w = 6;
    return w;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      bits.delete();
      fq.delete();
      m_ovf = 1'b0;
      m_on  = 1'b1;
    end else begin
      m_done = 1'b0;
      if (en) begin
        if (bits.size() == 0) m_w = width_of(mode);
        bits.push_back(din);
        if (bits.size() == m_w) begin
          m_val = 0;
          for (int i = 0; i < m_w; i++) begin
            if (Lsb) m_val = m_val + (int'(bits[i]) << i);
            else m_val = m_val * 2 + int'(bits[i]);
          end
          bits.delete();
          m_done = 1'b1;
        end
      end
      m_full = (fq.size() == Depth);
      m_pop  = (fq.size() != 0) && dout_ready;
      if (m_pop) void'(fq.pop_front());
      if (m_done) begin
        if (!m_full || m_pop) fq.push_back(m_val);
        else m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted symbols
  int got[$];
  always @(negedge clk) begin
    if (m_on) begin
      chk("dout_valid", 32'(dout_valid), 32'(fq.size() != 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (fq.size() != 0) chk("dout", 32'(dout), 32'(fq[0]));
      if (dout_valid && dout_ready) got.push_back(int'(dout));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic check_log(input string nm, input int n, input int e0, input int e1 = 0,
                           input int e2 = 0, input int e3 = 0, input int e4 = 0);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) chk($sformatf("%s_sym%0d", nm, i), 32'(got[i]), 32'(e[i]));
    end
  endtask

  initial begin
    int s1[6];
    int s1_exp[3];
    int gaps[6];
    int s2_bits[6];

    cyc();
    cyc();
    reset = 1'b0;
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);

    // Mode 01, back-to-back bits
    got.delete();
    s1 = '{1, 0, 0, 1, 1, 1};
    if (Lsb) s1_exp = '{1, 2, 3};
    else s1_exp = '{2, 1, 3};
    dout_ready = 1'b1;
    mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      en  = 1'b1;
      din = s1[i][0];
      cyc();
      chk($sformatf("m01_valid_after_bit%0d", i), 32'(dout_valid), 32'(i % 2 == 1));
      if (i % 2 == 1) chk($sformatf("m01_dout_after_bit%0d", i), 32'(dout), 32'(s1_exp[i / 2]));
    end
    idle(3);
    check_log("m01", 3, s1_exp[0], s1_exp[1], s1_exp[2]);

    // Mode 11 with en=0 gaps between bits
    got.delete();
    s2_bits = '{1, 0, 1, 1, 0, 1};
    gaps    = '{0, 2, 1, 0, 3, 1};
    mode = 2'b11;
    for (int i = 0; i < 6; i++) begin
      idle(gaps[i]);
      en  = 1'b1;
      din = s2_bits[i][0];
      cyc();
      chk($sformatf("m11_valid_after_bit%0d", i), 32'(dout_valid), 32'(i == 5));
    end
    chk("m11_dout", 32'(dout), 32'd45);
    idle(3);
    check_log("m11", 1, 45);

    // Mode change in the middle of a symbol takes effect only from the next symbol
    got.delete();
    mode = 2'b10;
    en = 1'b1; din = 1'b1; cyc();
    din = 1'b1; cyc();
    mode = 2'b01;
    din = 1'b0; cyc();
    din = 1'b0; cyc();
    din = 1'b1; cyc();
    din = 1'b0; cyc();
    idle(3);
    if (Lsb) check_log("modesw", 2, 3, 1);
    else check_log("modesw", 2, 12, 2);

    // Overflow: fifth symbol dropped, ovf sticks
    do_reset();
    got.delete();
    dout_ready = 1'b0;
    mode = 2'b00;
    s1 = '{1, 0, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; din = s1[i][0]; cyc();
    end
    idle(1);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_full_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    idle(6);
    check_log("ovf_drain", 4, 1, 0, 1, 1);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_empty", 32'(dout_valid), 32'd0);

    // Full FIFO with a pop in the same cycle the next symbol completes
    do_reset();
    chk("ovf_cleared", 32'(ovf), 32'd0);
    got.delete();
    dout_ready = 1'b0;
    mode = 2'b00;
    s1 = '{1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; din = s1[i][0]; cyc();
    end
    din = 1'b0;
    dout_ready = 1'b1;
    cyc();
    idle(7);
    chk("fullpop_ovf", 32'(ovf), 32'd0);
    check_log("fullpop", 5, 1, 1, 0, 1, 0);

    // Reset in the middle of a symbol with symbols already buffered
    got.delete();
    dout_ready = 1'b0;
    mode = 2'b11;
    s1 = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 15; i++) begin
      en = 1'b1; din = s1[i % 6][0]; cyc();
    end
    chk("pre_reset_valid", 32'(dout_valid), 32'd1);
    do_reset();
    chk("midreset_valid", 32'(dout_valid), 32'd0);
    chk("midreset_dout", 32'(dout), 32'd0);
    chk("midreset_ovf", 32'(ovf), 32'd0);
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = 1'b1; din = 1'b1; cyc();
    end
    chk("after_reset_dout", 32'(dout), 32'd63);
    idle(3);
    check_log("after_reset", 1, 63);

    // Mixed traffic, checked against the model every cycle
    for (int i = 0; i < 120; i++) begin
      en         = 1'($urandom_range(0, 1));
      din        = 1'($urandom_range(0, 1));
      mode       = 2'($urandom_range(0, 3));
      dout_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    dout_ready = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
